control_unit_hs: RTL and testbench
==================================

// Module: control_unit_hs
// PURPOSE
//  Multicycle RV64I control FSM, successor to the fixed-latency control unit. Adds a req/ready
//  memory handshake with wait states, a bus timeout, and a trap state for illegal opcodes.
//  Adds full JAL/JALR/LUI/AUIPC sequencing and optional RV64 W-ops.
//  Sits in the riscv top level and drives the PC, IR, ALU, register file and memory datapath.
// PARAMETERS
//  MEM_TIMEOUT   16  consecutive non-ready wait cycles before a bus-error trap; 0 disables the timeout
//  ENABLE_RV64W  1   1: OP_32 (0111011) and OP_IMM_32 (0011011) are legal; 0: they trap as illegal
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-high
//  op           in   7  opcode, IR[6:0]
//  mem_ready    in   1  memory completes the pending transfer this cycle
//  mem_req      out  1  memory transfer request
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load gated by the datapath branch flag
//  PCSource     out  2  00 ALU result, 01 ALUOut
//  IorD         out  1  0 PC address, 1 ALUOut address
//  MemRead      out  1  read strobe
//  MemWrite     out  1  write strobe
//  IRWrite      out  1  IR and OldPC load
//  WBSel        out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC
//  RegWrite     out  1  register file write
//  ALUSrcA      out  2  00 PC, 01 regA, 10 OldPC, 11 zero
//  ALUSrcB      out  2  00 regB, 01 const 4, 10 imm, 11 zero
//  ALUOp        out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
//  trap         out  1  core halted in TRAP
//  trap_cause   out  2  01 illegal opcode, 10 bus timeout, 00 none
//  currentState out  4  state encoding, for ALU_Control and debug
// BEHAVIOUR
//  - Moore outputs decoded from the state register, except handshake-qualified strobes (IRWrite, PCWrite in FETCH).
//  - While reset is high, every output is 0. currentState reads 0 (FETCH).
//  - States and transitions:
//    - FETCH(0): mem_req, MemRead, IorD=0. Waits for mem_ready.
//      On the handshake cycle: IRWrite=1 and PCWrite=1 with PC+4 (ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00). Then -> DECODE.
//    - DECODE(1): ALUOut <= OldPC+imm (ALUSrcA=10, ALUSrcB=10, ALUOp=00). Dispatch on op:
//      - LOAD/STORE -> MEM_ADDR(2)
//      - OP/OP_32 -> EXEC_R(6)
//      - OP_IMM/OP_IMM_32 -> EXEC_I(7)
//      - BRANCH -> BRANCH(9)
//      - JAL -> JUMP(11)
//      - JALR -> EXEC_JALR(10)
//      - LUI -> EXEC_LUI(12)
//      - AUIPC -> ALU_WB(8)
//      - anything else -> TRAP(13), cause 01
//    - MEM_ADDR(2): rs1+imm (01/10/00). LOAD -> MEM_RD(3); STORE -> MEM_WR(5).
//    - MEM_RD(3): mem_req, MemRead, IorD=1. On ready -> MEM_WB(4).
//    - MEM_WB(4): RegWrite, WBSel=01. -> FETCH.
//    - MEM_WR(5): mem_req, MemWrite, IorD=1. On ready -> FETCH.
//    - EXEC_R(6): ALUSrcA=01, ALUSrcB=00, ALUOp=10. -> ALU_WB.
//    - EXEC_I(7): ALUSrcA=01, ALUSrcB=10, ALUOp=11. -> ALU_WB.
//    - EXEC_LUI(12): ALUSrcA=11, ALUSrcB=10, ALUOp=00. -> ALU_WB.
//    - ALU_WB(8): RegWrite, WBSel=00. -> FETCH.
//    - BRANCH(9): ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. -> FETCH.
//    - EXEC_JALR(10): rs1+imm (01/10/00). -> JUMP.
//    - JUMP(11): RegWrite, WBSel=10, PCWrite, PCSource=01. -> FETCH. The datapath clears bit0 for JALR.
//    - TRAP(13): all strobes 0, trap=1, trap_cause held. Exited only by reset.
//  - Handshake: a transfer completes on any cycle with mem_req && mem_ready.
//    - mem_req is held, with stable IorD/MemRead/MemWrite, until completion.
//    - mem_ready while mem_req=0 is ignored. Zero-wait memory gives the minimum cycle counts below.
//  - Minimum latency: load 5 cycles; store 4; R/I/LUI/AUIPC 4 (AUIPC 3); branch 3; JAL 3; JALR 4.
//  - Timeout: a counter increments each wait-state cycle with mem_req && !mem_ready.
//    - It clears on state change. On the MEM_TIMEOUT-th consecutive stalled cycle -> TRAP, cause 10.
//    - If ready arrives in that same cycle, the handshake wins and there is no trap.
//  - Reset mid-transfer abandons the request. mem_req is 0 from the reset cycle onward.
//    After reset: FETCH, counter 0, trap_cause 00.
// STRUCTURE
//  - riscv_pkg: opcode constants, state codes (4-bit), ALUOp/ALUSrc/WBSel codes, trap cause codes.
//  - Sub-module mem_wait_timer: counter with clr/inc/expired and parameter MEM_TIMEOUT.
//  - Body: state register plus combinational next-state and output decode.
// TESTING
//  - Zero-wait: ADDI x1,x0,5 then ADD -> exactly 4 cycles each; RegWrite in ALU_WB; IRWrite one cycle per fetch.
//  - LW with mem_ready low 3 cycles in MEM_RD -> mem_req/IorD=1 held 4 cycles; MEM_WB follows; total 8 cycles.
//  - BEQ taken/not-taken -> PCWriteCond=1, PCSource=01 in BRANCH; JAL -> WBSel=10 + PCWrite in JUMP, 3 cycles.
//  - op=7'b1111111, and OP_32 with ENABLE_RV64W=0 -> TRAP; trap=1, cause=01; stays until reset.
//  - MEM_TIMEOUT=4, fetch never ready -> TRAP after 4 stalled cycles, cause 10.
//    Ready on the 4th stalled cycle -> no trap. MEM_TIMEOUT=0 -> never traps.
//  - reset asserted mid-MEM_WR wait -> next cycle FETCH, mem_req=0, MemWrite=0, currentState=0.

Source files
------------

// File: rtl/control_unit_hs_pkg.sv
// Shared constants for the handshaking multicycle RV64I control unit:
// state codes, opcodes, datapath select codes and trap causes.
package control_unit_hs_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_EXEC_JALR = 4'd10,
        S_JUMP      = 4'd11,
        S_EXEC_LUI  = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold mem_req and wait on mem_ready.
    function automatic logic isMemWait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/control_unit_hs_if.sv
// Control bundle between the control unit (master) and the datapath/memory (slave).
interface control_unit_hs_if;
    import control_unit_hs_pkg::*;

    logic [6:0]         op;
    logic               mem_ready;
    logic               mem_req;
    logic               PCWrite;
    logic               PCWriteCond;
    logic [1:0]         PCSource;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         WBSel;
    logic               RegWrite;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic               trap;
    logic [1:0]         trap_cause;
    logic [STATE_W-1:0] currentState;

    modport master (
        input  op, mem_ready,
        output mem_req, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
               IRWrite, WBSel, RegWrite, ALUSrcA, ALUSrcB, ALUOp, trap, trap_cause,
               currentState
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
               IRWrite, WBSel, RegWrite, ALUSrcA, ALUSrcB, ALUOp, trap, trap_cause,
               currentState
    );

endinterface

// File: rtl/control_unit_hs_mem_wait_timer.sv
// Counts consecutive stalled wait cycles; expired flags the MEM_TIMEOUT-th one.
// MEM_TIMEOUT = 0 never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LAST_INT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_INT);

    logic [CW-1:0] countReg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            countReg <= '0;
        end else if (inc) begin
            countReg <= countReg + 1'b1;
        end
    end

    // Fires during the stalled cycle itself so the FSM can leave on that edge.
    assign expired = (MEM_TIMEOUT != 0) && inc && (countReg == LAST);

endmodule

// File: rtl/control_unit_hs.sv
// Multicycle RV64I control FSM with req/ready memory handshake, bus timeout
// and an illegal-opcode / bus-error trap state.
module control_unit_hs
    import control_unit_hs_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit ENABLE_RV64W = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    control_unit_hs_if.master  bus
);
    state_t     stateReg, stateNext;
    logic [1:0] causeReg, causeNext;
    logic       memWait, handshake, stall, timerExpired, illegal;

    assign memWait   = isMemWait(stateReg);
    assign handshake = memWait && bus.mem_ready;
    assign stall     = memWait && !bus.mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .srst    (reset),
        .clr     (stateNext != stateReg),
        .inc     (stall),
        .expired (timerExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= S_FETCH;
            causeReg <= CAUSE_NONE;
        end else begin
            stateReg <= stateNext;
            causeReg <= causeNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        causeNext = causeReg;
        illegal   = 1'b0;
        case (stateReg)
            S_FETCH:     if (handshake) stateNext = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OPC_LOAD, OPC_STORE: stateNext = S_MEM_ADDR;
                    OPC_OP:              stateNext = S_EXEC_R;
                    OPC_OP_IMM:          stateNext = S_EXEC_I;
                    OPC_OP_32:     if (ENABLE_RV64W) stateNext = S_EXEC_R; else illegal = 1'b1;
                    OPC_OP_IMM_32: if (ENABLE_RV64W) stateNext = S_EXEC_I; else illegal = 1'b1;
                    OPC_BRANCH:          stateNext = S_BRANCH;
                    OPC_JAL:             stateNext = S_JUMP;
                    OPC_JALR:            stateNext = S_EXEC_JALR;
                    OPC_LUI:             stateNext = S_EXEC_LUI;
                    OPC_AUIPC:           stateNext = S_ALU_WB;
                    default:             illegal   = 1'b1;
                endcase
            end
            S_MEM_ADDR:  stateNext = (bus.op == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (handshake) stateNext = S_MEM_WB;
            S_MEM_WR:    if (handshake) stateNext = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: stateNext = S_ALU_WB;
            S_EXEC_JALR: stateNext = S_JUMP;
            S_TRAP:      stateNext = S_TRAP;
            default:     stateNext = S_FETCH;
        endcase
        if (illegal) begin
            stateNext = S_TRAP;
            causeNext = CAUSE_ILLEGAL;
        end
        // Only reachable on a stalled cycle, so a same-cycle handshake always wins.
        if (timerExpired) begin
            stateNext = S_TRAP;
            causeNext = CAUSE_TIMEOUT;
        end
    end

    // Outputs are forced low combinationally while reset is held.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.PCSource     = PCSRC_ALU;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.WBSel        = WB_ALUOUT;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = SRCA_PC;
        bus.ALUSrcB      = SRCB_REG;
        bus.ALUOp        = ALUOP_ADD;
        bus.trap         = 1'b0;
        bus.trap_cause   = CAUSE_NONE;
        bus.currentState = reset ? S_FETCH : stateReg;
        if (!reset) begin
            case (stateReg)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = SRCB_FOUR;
                    bus.IRWrite = handshake;
                    bus.PCWrite = handshake;
                end
                S_DECODE: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEM_ADDR, S_EXEC_JALR: begin
                    bus.ALUSrcA = SRCA_REG;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    bus.mem_req = 1'b1;
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.WBSel    = WB_MDR;
                end
                S_MEM_WR: begin
                    bus.mem_req  = 1'b1;
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC_R: begin
                    bus.ALUSrcA = SRCA_REG;
                    bus.ALUOp   = ALUOP_RTYPE;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA = SRCA_REG;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ALUOp   = ALUOP_ITYPE;
                end
                S_EXEC_LUI: begin
                    bus.ALUSrcA = SRCA_ZERO;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_ALU_WB:   bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA     = SRCA_REG;
                    bus.ALUOp       = ALUOP_BRANCH;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    bus.RegWrite = 1'b1;
                    bus.WBSel    = WB_PC;
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PCSRC_ALUOUT;
                end
                S_TRAP: begin
                    bus.trap       = 1'b1;
                    bus.trap_cause = causeReg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_hs.sv
// Randomized instruction-stream bench for control_unit_hs, checked each cycle
// against per-opcode state sequences and a per-state output table.
module tb_control_unit_hs;

    typedef struct packed {
        logic       memReq;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] wbSel;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       trap;
        logic [1:0] trapCause;
        logic [3:0] state;
    } ctl_t;

    typedef int intq_t[$];

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OP32   = 7'b0111011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_OPIMM32= 7'b0011011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic clk = 1'b0;
    logic resetA = 1'b1;
    logic resetB = 1'b1;
    logic selB = 1'b0;
    logic [6:0] opDrv = '0;
    logic readyDrv = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_unit_hs_if busA ();
    control_unit_hs_if busB ();

    assign busA.op = opDrv;
    assign busA.mem_ready = readyDrv;
    assign busB.op = opDrv;
    assign busB.mem_ready = readyDrv;

    control_unit_hs #(.MEM_TIMEOUT(4), .ENABLE_RV64W(1'b1)) dutA (
        .clk(clk), .reset(resetA), .bus(busA.master));
    control_unit_hs #(.MEM_TIMEOUT(0), .ENABLE_RV64W(1'b0)) dutB (
        .clk(clk), .reset(resetB), .bus(busB.master));

    ctl_t obsA, obsB, obs;
    always_comb begin
        obsA = {busA.mem_req, busA.PCWrite, busA.PCWriteCond, busA.PCSource, busA.IorD,
                busA.MemRead, busA.MemWrite, busA.IRWrite, busA.WBSel, busA.RegWrite,
                busA.ALUSrcA, busA.ALUSrcB, busA.ALUOp, busA.trap, busA.trap_cause,
                busA.currentState};
        obsB = {busB.mem_req, busB.PCWrite, busB.PCWriteCond, busB.PCSource, busB.IorD,
                busB.MemRead, busB.MemWrite, busB.IRWrite, busB.WBSel, busB.RegWrite,
                busB.ALUSrcA, busB.ALUSrcB, busB.ALUOp, busB.trap, busB.trap_cause,
                busB.currentState};
        obs = selB ? obsB : obsA;
    end

    task automatic checkVec(input string tag, input ctl_t got, input ctl_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output table for each state, straight from the state descriptions.
    function automatic ctl_t expVec(input int st, input logic rdy, input logic [1:0] cause);
        ctl_t e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.memReq = 1; e.memRead = 1; e.aluSrcB = 2'b01;
                      if (rdy) begin e.irWrite = 1; e.pcWrite = 1; end end
            1:  begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b10; end
            2:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; end
            3:  begin e.memReq = 1; e.memRead = 1; e.iorD = 1; end
            4:  begin e.regWrite = 1; e.wbSel = 2'b01; end
            5:  begin e.memReq = 1; e.memWrite = 1; e.iorD = 1; end
            6:  begin e.aluSrcA = 2'b01; e.aluOp = 2'b10; end
            7:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.aluOp = 2'b11; end
            8:  begin e.regWrite = 1; end
            9:  begin e.aluSrcA = 2'b01; e.aluOp = 2'b01; e.pcWriteCond = 1; e.pcSource = 2'b01; end
            10: begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; end
            11: begin e.regWrite = 1; e.wbSel = 2'b10; e.pcWrite = 1; e.pcSource = 2'b01; end
            12: begin e.aluSrcA = 2'b11; e.aluSrcB = 2'b10; end
            13: begin e.trap = 1; e.trapCause = cause; end
            default: ;
        endcase
        return e;
    endfunction

    // Full state walk of one instruction; 13 marks an illegal-opcode trap.
    function automatic intq_t buildSeq(input logic [6:0] o, input bit rv64w);
        intq_t q;
        case (o)
            T_LOAD:    q = '{0, 1, 2, 3, 4};
            T_STORE:   q = '{0, 1, 2, 5};
            T_OP:      q = '{0, 1, 6, 8};
            T_OPIMM:   q = '{0, 1, 7, 8};
            T_OP32:    q = rv64w ? '{0, 1, 6, 8} : '{0, 1, 13};
            T_OPIMM32: q = rv64w ? '{0, 1, 7, 8} : '{0, 1, 13};
            T_BRANCH:  q = '{0, 1, 9};
            T_JAL:     q = '{0, 1, 11};
            T_JALR:    q = '{0, 1, 10, 11};
            T_LUI:     q = '{0, 1, 12, 8};
            T_AUIPC:   q = '{0, 1, 8};
            default:   q = '{0, 1, 13};
        endcase
        return q;
    endfunction

    function automatic logic [6:0] pickOp();
        case ($urandom_range(0, 13))
            0: return T_LOAD;   1: return T_STORE;  2: return T_OP;
            3: return T_OP32;   4: return T_OPIMM;  5: return T_OPIMM32;
            6: return T_BRANCH; 7: return T_JAL;    8: return T_JALR;
            9: return T_LUI;   10: return T_AUIPC; 11: return 7'b1111111;
            12: return T_LOAD;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic setReset(input logic v);
        if (selB) resetB = v; else resetA = v;
    endtask

    // One cycle: inputs already driven after the edge; sample on the falling edge.
    task automatic cycleCheck(input string tag, input ctl_t exp);
        @(negedge clk);
        checkVec(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic runPhase(input bit useB, input int nInstr, input int timeout, input bit rv64w);
        intq_t seq;
        logic [6:0] o;
        int mode, stall, cycles;
        bit trapped, aborted, done;
        logic [1:0] cause;
        logic rdy;
        selB = useB;
        resetA = 1'b1;
        resetB = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin
            opDrv = pickOp();
            readyDrv = 1'($urandom_range(0, 1));
            cycleCheck("reset", '0);
        end
        setReset(1'b0);
        for (int n = 0; n < nInstr; n++) begin
            o = pickOp();
            seq = buildSeq(o, rv64w);
            mode = $urandom_range(0, 9);
            opDrv = o;
            cycles = 0;
            trapped = 0;
            aborted = 0;
            cause = 2'b00;
            for (int i = 0; i < seq.size() && !trapped && !aborted; i++) begin
                if (seq[i] == 13) begin
                    trapped = 1;
                    cause = 2'b01;
                end else if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
                    stall = 0;
                    done = 0;
                    while (!done) begin
                        if (mode < 4)       rdy = 1'b1;
                        else if (mode < 9)  rdy = 1'($urandom_range(0, 1));
                        else                rdy = (stall >= 40);
                        readyDrv = rdy;
                        if (!rdy && $urandom_range(0, 49) == 0) begin
                            setReset(1'b1);
                            cycleCheck($sformatf("resetMidXfer st%0d", seq[i]), '0);
                            setReset(1'b0);
                            aborted = 1;
                            done = 1;
                        end else begin
                            cycleCheck($sformatf("st%0d op%b", seq[i], o), expVec(seq[i], rdy, 2'b00));
                            cycles++;
                            if (rdy) begin
                                done = 1;
                            end else begin
                                stall++;
                                if (timeout != 0 && stall == timeout) begin
                                    trapped = 1;
                                    cause = 2'b10;
                                    done = 1;
                                end
                            end
                        end
                    end
                end else begin
                    readyDrv = 1'($urandom_range(0, 1));
                    cycleCheck($sformatf("st%0d op%b", seq[i], o), expVec(seq[i], 1'b0, 2'b00));
                    cycles++;
                end
            end
            if (trapped) begin
                repeat ($urandom_range(2, 5)) begin
                    readyDrv = 1'($urandom_range(0, 1));
                    opDrv = pickOp();
                    cycleCheck("trapHold", expVec(13, 1'b0, cause));
                end
                setReset(1'b1);
                cycleCheck("trapReset", '0);
                setReset(1'b0);
            end
            $display("txn %0d dut=%s op=%b cycles=%0d trap=%0d abort=%0d",
                     n, useB ? "B" : "A", o, cycles, trapped, aborted);
        end
    endtask

    initial begin
        runPhase(1'b0, 500, 4, 1'b1);
        runPhase(1'b1, 300, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
